// File: rtl/ram_dp_arb.sv
// rtl/ram_dp_arb.sv - dual-port byte-enable RAM with valid/ready requests and collision arbitration
// Same-address conflicts involving a write stall one port; priority alternates so neither starves.
module ram_dp_arb #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_WIDTH  = 10,
  parameter int    OUT_REG     = 0,
  parameter int    WRITE_FIRST = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req_valid,
  output logic                    a_req_ready,
  input  logic [DATA_WIDTH/8-1:0] a_req_we,
  input  logic [ADDR_WIDTH-1:0]   a_req_addr,
  input  logic [DATA_WIDTH-1:0]   a_req_wdata,
  output logic                    a_rsp_valid,
  output logic [DATA_WIDTH-1:0]   a_rsp_data,
  input  logic                    b_req_valid,
  output logic                    b_req_ready,
  input  logic [DATA_WIDTH/8-1:0] b_req_we,
  input  logic [ADDR_WIDTH-1:0]   b_req_addr,
  input  logic [DATA_WIDTH-1:0]   b_req_wdata,
  output logic                    b_rsp_valid,
  output logic [DATA_WIDTH-1:0]   b_rsp_data
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  prio;
  logic                  collide;
  logic [1:0]            acc;
  logic [1:0]            rsp_v;
  logic [NB-1:0]         we     [2];
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [DATA_WIDTH-1:0] wdata  [2];
  logic [DATA_WIDTH-1:0] old    [2];
  logic [DATA_WIDTH-1:0] merged [2];
  logic [DATA_WIDTH-1:0] rsp_d  [2];

  assign we[0]    = a_req_we;
  assign we[1]    = b_req_we;
  assign addr[0]  = a_req_addr;
  assign addr[1]  = b_req_addr;
  assign wdata[0] = a_req_wdata;
  assign wdata[1] = b_req_wdata;

  // Read/read to one address is harmless; only a write makes it a conflict.
  assign collide     = a_req_valid & b_req_valid & (a_req_addr == b_req_addr) &
                       ((|a_req_we) | (|b_req_we));
  assign a_req_ready = ~reset & (~collide | ~prio);
  assign b_req_ready = ~reset & (~collide | prio);
  assign acc         = {b_req_valid & b_req_ready, a_req_valid & a_req_ready};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (collide) begin
      prio <= ~prio;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      old[p]    = mem[addr[p]];
      merged[p] = old[p];
      for (int i = 0; i < NB; i++) begin
        if (we[p][i]) merged[p][8*i +: 8] = wdata[p][8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NB; i++) begin
        if (acc[p] && we[p][i]) mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
      end
    end
  end

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rsp
      logic                  v1;
      logic [DATA_WIDTH-1:0] d1;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) v1 <= 1'b0;
        else       v1 <= acc[p];
      end

      // Data registers carry no reset so they simply hold between responses.
      always_ff @(posedge clk) begin
        if (acc[p]) d1 <= (WRITE_FIRST != 0) ? merged[p] : old[p];
      end

      if (OUT_REG != 0) begin : g_oreg
        logic                  v2;
        logic [DATA_WIDTH-1:0] d2;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) v2 <= 1'b0;
          else       v2 <= v1;
        end

        always_ff @(posedge clk) begin
          if (v1) d2 <= d1;
        end

        assign rsp_v[p] = v2;
        assign rsp_d[p] = d2;
      end else begin : g_noreg
        assign rsp_v[p] = v1;
        assign rsp_d[p] = d1;
      end
    end
  endgenerate

  assign a_rsp_valid = rsp_v[0];
  assign a_rsp_data  = rsp_d[0];
  assign b_rsp_valid = rsp_v[1];
  assign b_rsp_data  = rsp_d[1];
endmodule

// File: tb/tb_ram_dp_arb.sv
// tb/tb_ram_dp_arb.sv - directed bench for ram_dp_arb
// u0: latency 1 read-first, u1: latency 2 write-first, both driven with identical requests.
module tb_ram_dp_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_req_valid, b_req_valid;
  logic [3:0]  a_req_we, b_req_we;
  logic [9:0]  a_req_addr, b_req_addr;
  logic [31:0] a_req_wdata, b_req_wdata;

  logic        a_rdy0, b_rdy0, a_rv0, b_rv0;
  logic        a_rdy1, b_rdy1, a_rv1, b_rv1;
  logic [31:0] a_rd0, b_rd0, a_rd1, b_rd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_dp_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .OUT_REG(0), .WRITE_FIRST(0)) u0 (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_rdy0), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rv0), .a_rsp_data(a_rd0),
    .b_req_valid(b_req_valid), .b_req_ready(b_rdy0), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rv0), .b_rsp_data(b_rd0)
  );

  ram_dp_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .OUT_REG(1), .WRITE_FIRST(1)) u1 (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_rdy1), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rv1), .a_rsp_data(a_rd1),
    .b_req_valid(b_req_valid), .b_req_ready(b_rdy1), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rv1), .b_rsp_data(b_rd1)
  );

  typedef struct {
    logic        av;  logic [3:0] awe; logic [9:0] aa; logic [31:0] ad;
    logic        bv;  logic [3:0] bwe; logic [9:0] ba; logic [31:0] bd;
    logic        ar;  logic       br;
    logic [31:0] a_rf; logic [31:0] a_wf; logic [31:0] b_rf; logic [31:0] b_wf;
    logic        a_k; logic       b_k;
  } vec_t;

  vec_t tv [25];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] awe, input logic [9:0] aa,
                       input logic [31:0] ad, input logic bv, input logic [3:0] bwe,
                       input logic [9:0] ba, input logic [31:0] bd);
    a_req_valid = av; a_req_we = awe; a_req_addr = aa; a_req_wdata = ad;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = ba; b_req_wdata = bd;
  endtask

  initial begin
    logic pa, pb, ea, eb;
    logic [31:0] pa_wf, pb_wf;

    //       av awe   aa      ad            bv bwe   ba      bd            ar br a_rf          a_wf          b_rf          b_wf          ak bk
    tv[0]  = '{1, 4'hF, 10'd5,  32'hDEADBEEF, 0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        0, 0};
    tv[1]  = '{1, 4'h0, 10'd5,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        1, 0};
    tv[2]  = '{1, 4'hF, 10'd7,  32'h11223344, 1, 4'hF, 10'd8,  32'hCAFEF00D, 1, 1, 32'h0,        32'h11223344, 32'h0,        32'hCAFEF00D, 0, 0};
    tv[3]  = '{1, 4'h5, 10'd7,  32'hAABBCCDD, 1, 4'h0, 10'd8,  32'h0,        1, 1, 32'h11223344, 32'h11BB33DD, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1};
    tv[4]  = '{1, 4'hF, 10'd9,  32'h55AA55AA, 0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h0,        32'h55AA55AA, 32'h0,        32'h0,        0, 0};
    tv[5]  = '{1, 4'h0, 10'd9,  32'h0,        1, 4'h0, 10'd9,  32'h0,        1, 1, 32'h55AA55AA, 32'h55AA55AA, 32'h55AA55AA, 32'h55AA55AA, 1, 1};
    tv[6]  = '{1, 4'h0, 10'd7,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h11BB33DD, 32'h11BB33DD, 32'h0,        32'h0,        1, 0};
    tv[7]  = '{1, 4'hF, 10'd3,  32'h1,        1, 4'hF, 10'd3,  32'h2,        1, 0, 32'h0,        32'h1,        32'h0,        32'h2,        0, 0};
    tv[8]  = '{1, 4'hF, 10'd3,  32'h1,        1, 4'hF, 10'd3,  32'h2,        0, 1, 32'h0,        32'h1,        32'h1,        32'h2,        0, 1};
    tv[9]  = '{1, 4'hF, 10'd3,  32'h1,        1, 4'hF, 10'd3,  32'h2,        1, 0, 32'h2,        32'h1,        32'h0,        32'h2,        1, 0};
    tv[10] = '{1, 4'hF, 10'd3,  32'h1,        1, 4'hF, 10'd3,  32'h2,        0, 1, 32'h0,        32'h1,        32'h1,        32'h2,        0, 1};
    tv[11] = '{1, 4'h0, 10'd3,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h2,        32'h2,        32'h0,        32'h0,        1, 0};
    tv[12] = '{1, 4'h0, 10'd3,  32'h0,        1, 4'h3, 10'd3,  32'h4,        1, 0, 32'h2,        32'h2,        32'h0,        32'h4,        1, 0};
    tv[13] = '{1, 4'h0, 10'd3,  32'h0,        1, 4'h3, 10'd3,  32'h4,        0, 1, 32'h0,        32'h0,        32'h2,        32'h4,        0, 1};
    tv[14] = '{1, 4'h0, 10'd3,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h4,        32'h4,        32'h0,        32'h0,        1, 0};
    tv[15] = '{1, 4'hF, 10'd0,  32'h0BADC0DE, 1, 4'hF, 10'h3FF, 32'hFEEDFACE, 1, 1, 32'h0,       32'h0BADC0DE, 32'h0,        32'hFEEDFACE, 0, 0};
    tv[16] = '{1, 4'h0, 10'h3FF, 32'h0,       1, 4'h0, 10'd0,  32'h0,        1, 1, 32'hFEEDFACE, 32'hFEEDFACE, 32'h0BADC0DE, 32'h0BADC0DE, 1, 1};
    tv[17] = '{1, 4'hF, 10'd1,  32'h10101010, 0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h0,        32'h10101010, 32'h0,        32'h0,        0, 0};
    tv[18] = '{1, 4'hF, 10'd2,  32'h20202020, 0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h0,        32'h20202020, 32'h0,        32'h0,        0, 0};
    tv[19] = '{1, 4'h0, 10'd0,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h0BADC0DE, 32'h0BADC0DE, 32'h0,        32'h0,        1, 0};
    tv[20] = '{1, 4'h0, 10'd1,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h10101010, 32'h10101010, 32'h0,        32'h0,        1, 0};
    tv[21] = '{1, 4'h0, 10'd2,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h20202020, 32'h20202020, 32'h0,        32'h0,        1, 0};
    tv[22] = '{1, 4'h0, 10'd3,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h4,        32'h4,        32'h0,        32'h0,        1, 0};
    tv[23] = '{0, 4'h0, 10'd0,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0};
    tv[24] = '{0, 4'h0, 10'd0,  32'h0,        0, 4'h0, 10'd0,  32'h0,        1, 1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0};

    reset = 1'b1;
    drive(1, 4'hF, 10'd5, 32'h0, 1, 4'h0, 10'd6, 32'h0);
    repeat (2) @(negedge clk);
    check("reset a_ready u0", {31'b0, a_rdy0}, 32'd0);
    check("reset b_ready u1", {31'b0, b_rdy1}, 32'd0);
    check("reset a_rsp_valid u0", {31'b0, a_rv0}, 32'd0);
    check("reset a_rsp_valid u1", {31'b0, a_rv1}, 32'd0);
    drive(0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    reset = 1'b0;

    pa = 1'b0; pb = 1'b0; pa_wf = '0; pb_wf = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(tv[i].av, tv[i].awe, tv[i].aa, tv[i].ad, tv[i].bv, tv[i].bwe, tv[i].ba, tv[i].bd);
      #1;
      check($sformatf("v%0d a_ready u0", i), {31'b0, a_rdy0}, {31'b0, tv[i].ar});
      check($sformatf("v%0d b_ready u0", i), {31'b0, b_rdy0}, {31'b0, tv[i].br});
      check($sformatf("v%0d a_ready u1", i), {31'b0, a_rdy1}, {31'b0, tv[i].ar});
      check($sformatf("v%0d b_ready u1", i), {31'b0, b_rdy1}, {31'b0, tv[i].br});
      @(posedge clk);
      #1;
      ea = tv[i].av & tv[i].ar;
      eb = tv[i].bv & tv[i].br;
      check($sformatf("v%0d a_rsp_valid u0", i), {31'b0, a_rv0}, {31'b0, ea});
      check($sformatf("v%0d b_rsp_valid u0", i), {31'b0, b_rv0}, {31'b0, eb});
      if (ea && tv[i].a_k) check($sformatf("v%0d a_rsp_data u0", i), a_rd0, tv[i].a_rf);
      if (eb && tv[i].b_k) check($sformatf("v%0d b_rsp_data u0", i), b_rd0, tv[i].b_rf);
      check($sformatf("v%0d a_rsp_valid u1", i), {31'b0, a_rv1}, {31'b0, pa});
      check($sformatf("v%0d b_rsp_valid u1", i), {31'b0, b_rv1}, {31'b0, pb});
      if (pa) check($sformatf("v%0d a_rsp_data u1", i), a_rd1, pa_wf);
      if (pb) check($sformatf("v%0d b_rsp_data u1", i), b_rd1, pb_wf);
      pa = ea; pa_wf = tv[i].a_wf;
      pb = eb; pb_wf = tv[i].b_wf;
    end
    check("hold a_rsp_data u0", a_rd0, 32'h4);
    check("hold a_rsp_data u1", a_rd1, 32'h4);

    // Reset with a response in flight on the latency-2 instance.
    @(negedge clk);
    drive(1, 4'hF, 10'h20, 32'h12345678, 1, 4'hF, 10'h20, 32'h0);
    #1;
    check("pre-reset collide a_ready", {31'b0, a_rdy0}, 32'd1);
    check("pre-reset collide b_ready", {31'b0, b_rdy0}, 32'd0);
    @(negedge clk);
    drive(1, 4'h0, 10'h20, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    @(posedge clk);
    #1;
    check("inflight accept u0 valid", {31'b0, a_rv0}, 32'd1);
    check("inflight accept u0 data", a_rd0, 32'h12345678);
    check("write echo u1 valid", {31'b0, a_rv1}, 32'd1);
    check("write echo u1 data", a_rd1, 32'h12345678);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset mid a_ready u0", {31'b0, a_rdy0}, 32'd0);
    check("reset mid a_ready u1", {31'b0, a_rdy1}, 32'd0);
    check("reset async clear u1", {31'b0, a_rv1}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("in reset %0d valid u0", i), {31'b0, a_rv0}, 32'd0);
      check($sformatf("in reset %0d valid u1", i), {31'b0, a_rv1}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1, 4'hF, 10'h21, 32'h1, 1, 4'hF, 10'h21, 32'h2);
    #1;
    check("post-reset prio a_ready", {31'b0, a_rdy0}, 32'd1);
    check("post-reset prio b_ready", {31'b0, b_rdy0}, 32'd0);
    @(posedge clk);
    #1;
    check("post-reset no stale u1", {31'b0, a_rv1}, 32'd0);
    check("post-reset b no pulse u0", {31'b0, b_rv0}, 32'd0);
    @(negedge clk);
    drive(1, 4'h0, 10'h20, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    @(posedge clk);
    #1;
    check("retained read u0 valid", {31'b0, a_rv0}, 32'd1);
    check("retained read u0 data", a_rd0, 32'h12345678);
    @(negedge clk);
    drive(0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    @(posedge clk);
    #1;
    check("retained read u1 valid", {31'b0, a_rv1}, 32'd1);
    check("retained read u1 data", a_rd1, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
